// File: rtl/core_sequencer.sv
// core_sequencer: streams NUM_CHUNKS operand chunks from the buffers into the MAC core,
// waits for accumulator_done (or a timeout) and returns the result over valid/ready. Rev 1.0
`default_nettype none

module core_sequencer #(
    parameter int WIDTH           = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 64,
    parameter int ADDR_WIDTH      = 6,
    parameter int TIMEOUT         = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        rd_en_o,
    output logic [ADDR_WIDTH-1:0]       rd_addr_o,
    input  logic [WIDTH*CHUNK_SIZE-1:0] rd_data_w_i,
    input  logic [WIDTH*CHUNK_SIZE-1:0] rd_data_n_i,
    output logic                        core_en_o,
    output logic                        core_reset_acc_o,
    output logic [WIDTH*CHUNK_SIZE-1:0] core_input_w_o,
    output logic [WIDTH*CHUNK_SIZE-1:0] core_input_n_o,
    input  logic                        core_accumulator_done_i,
    input  logic [WIDTH*CHUNK_SIZE-1:0] core_out_i,
    output logic [WIDTH*CHUNK_SIZE-1:0] out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);

    localparam int                    DW         = WIDTH * CHUNK_SIZE;
    localparam int                    NUM_CHUNKS = INNER_DIMENSION / BLOCK_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_CHUNK = ADDR_WIDTH'(NUM_CHUNKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [7:0]            LAST_WAIT  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_WAIT   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] chunk_q, chunk_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  error_q, error_d;
    logic [DW-1:0]         out_data_q, out_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            chunk_q    <= '0;
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        chunk_d          = chunk_q;
        wait_cnt_d       = wait_cnt_q;
        error_d          = error_q;
        out_data_d       = out_data_q;
        rd_en_o          = 1'b0;
        rd_addr_o        = '0;
        core_en_o        = 1'b0;
        core_reset_acc_o = 1'b0;
        core_input_w_o   = '0;
        core_input_n_o   = '0;
        out_valid_o      = 1'b0;
        done_o           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    error_d = 1'b0;
                end
            end
            S_CLEAR: begin
                // Prefetch chunk 0 so it lands on the first FEED cycle.
                core_reset_acc_o = 1'b1;
                rd_en_o          = 1'b1;
                chunk_d          = '0;
                state_d          = S_FEED;
            end
            S_FEED: begin
                core_en_o      = 1'b1;
                core_input_w_o = rd_data_w_i;
                core_input_n_o = rd_data_n_i;
                if (chunk_q == LAST_CHUNK) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = chunk_q + ADDR_ONE;
                    chunk_d   = chunk_q + ADDR_ONE;
                end
            end
            S_WAIT: begin
                // Inputs stay zero while enabled so the systolic pipeline drains.
                core_en_o = 1'b1;
                if (core_accumulator_done_i) begin
                    out_data_d = core_out_i;
                    state_d    = S_OUTPUT;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    error_d    = 1'b1;
                    out_data_d = '0;
                    state_d    = S_OUTPUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_OUTPUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign error_o    = error_q;
    assign out_data_o = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed blocks with a result scoreboard, buffer and core models.
`default_nettype none

module tb_core_sequencer;

    localparam int DW  = 64;
    localparam int AW  = 6;
    localparam int NCH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, error_o, rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_w = '0, rd_data_n = '0;
    logic          core_en_o, core_reset_acc_o;
    logic [DW-1:0] core_input_w_o, core_input_n_o;
    logic          core_accumulator_done_i;
    logic [DW-1:0] core_out_i;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;

    core_sequencer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start_i                (start_i),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .error_o                (error_o),
        .rd_en_o                (rd_en_o),
        .rd_addr_o              (rd_addr_o),
        .rd_data_w_i            (rd_data_w),
        .rd_data_n_i            (rd_data_n),
        .core_en_o              (core_en_o),
        .core_reset_acc_o       (core_reset_acc_o),
        .core_input_w_o         (core_input_w_o),
        .core_input_n_o         (core_input_n_o),
        .core_accumulator_done_i(core_accumulator_done_i),
        .core_out_i             (core_out_i),
        .out_data_o             (out_data_o),
        .out_valid_o            (out_valid_o),
        .out_ready_i            (out_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            ens;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    int            fi = 0;
    int            rd_cnt = 0;
    int            en_cnt = 0;
    int            racc_cnt = 0;
    bit            core_done_en = 1'b0;
    logic [DW-1:0] core_result = '0;

    function automatic logic [DW-1:0] chunk_w(int k);
        return {4{16'(k)}};
    endfunction

    function automatic logic [DW-1:0] chunk_n(int k);
        return {4{16'(k + 100)}};
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operand buffers: synchronous read, one cycle latency.
    always @(posedge clk) begin
        if (rd_en_o) begin
            rd_data_w <= chunk_w(int'(rd_addr_o));
            rd_data_n <= chunk_n(int'(rd_addr_o));
        end
    end

    // Core model: counts enabled cycles since the accumulator clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                en_cnt <= 0;
        else if (core_reset_acc_o) en_cnt <= 0;
        else if (core_en_o)        en_cnt <= en_cnt + 1;
    end
    assign core_accumulator_done_i = core_done_en && (en_cnt == NCH + 3);
    assign core_out_i              = core_result;

    // Read/feed monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            fi     = 0;
            rd_cnt = 0;
        end else begin
            if (core_reset_acc_o) begin
                racc_cnt++;
                fi     = 0;
                rd_cnt = 0;
                chk("reset_acc_without_en", {63'd0, core_en_o}, '0);
            end
            if (rd_en_o) begin
                chk("rd_addr", {58'd0, rd_addr_o}, DW'(rd_cnt));
                rd_cnt++;
            end
            if (core_en_o) begin
                if (fi < NCH) begin
                    chk("core_input_w", core_input_w_o, chunk_w(fi));
                    chk("core_input_n", core_input_n_o, chunk_n(fi));
                    fi++;
                end else begin
                    chk("flush_zero", core_input_w_o | core_input_n_o, '0);
                end
            end
        end
    end

    // Output monitor / scoreboard.
    logic          prev_v = 1'b0, prev_hs = 1'b0;
    logic [DW-1:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            chk("done_vs_handshake", {63'd0, done_o}, {63'd0, out_valid_o && out_ready_i});
            if (prev_v && !prev_hs) begin
                chk("valid_held", {63'd0, out_valid_o}, 64'd1);
                chk("data_held", out_data_o, prev_d);
            end
            if (out_valid_o && out_ready_i) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", out_data_o);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data_o, e.data);
                    chk("error_at_result", {63'd0, error_o}, {63'd0, e.err});
                    chk("core_en_cycles", DW'(en_cnt), DW'(e.ens));
                    chk("rd_en_count", DW'(rd_cnt), DW'(NCH));
                end
            end
            prev_v  = out_valid_o;
            prev_hs = out_valid_o && out_ready_i;
            prev_d  = out_data_o;
        end
    end

    task automatic check_idle(string tag);
        chk({tag, "_busy"}, {63'd0, busy_o}, '0);
        chk({tag, "_strobes"}, {59'd0, rd_en_o, core_en_o, core_reset_acc_o, done_o, out_valid_o}, '0);
        chk({tag, "_error"}, {63'd0, error_o}, '0);
        chk({tag, "_rd_addr"}, {58'd0, rd_addr_o}, '0);
        chk({tag, "_core_input"}, core_input_w_o | core_input_n_o, '0);
        chk({tag, "_out_data"}, out_data_o, '0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        chk("clear_reset_acc", {63'd0, core_reset_acc_o}, 64'd1);
        chk("error_cleared", {63'd0, error_o}, '0);
        @(negedge clk);
        chk("first_core_en", {63'd0, core_en_o}, 64'd1);
    endtask

    task automatic run_block(input logic [DW-1:0] res, input bit with_done, input bit bp,
                             input bit start_in_hs, input bit start_in_feed);
        int h0;
        core_result  = res;
        core_done_en = with_done;
        q.push_back('{with_done ? res : '0, !with_done, with_done ? NCH + 4 : NCH + 255});
        out_ready_i  = !bp;
        h0           = hs_cnt;
        pulse_start();
        if (start_in_feed) begin
            for (int i = 0; i < 60; i++) begin
                @(posedge clk); #1;
                if (fi >= 5) break;
            end
            start_i = 1'b1;
            @(posedge clk); #1 start_i = 1'b0;
        end
        if (bp) begin
            for (int i = 0; i < 600; i++) begin
                @(posedge clk); #1;
                if (out_valid_o) break;
            end
            repeat (10) @(posedge clk);
            #1 out_ready_i = 1'b1;
            start_i = start_in_hs;
            @(posedge clk); #1 out_ready_i = 1'b0;
            start_i = 1'b0;
        end else begin
            for (int i = 0; i < 600; i++) begin
                @(posedge clk);
                if (hs_cnt != h0) break;
            end
            #1 out_ready_i = 1'b0;
        end
        if (hs_cnt == h0) begin
            checks++;
            errors++;
            $display("FAIL handshake_missing: got %0d results expected %0d", hs_cnt, h0 + 1);
        end
    endtask

    initial begin
        int r0;
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk); #1 start_i = ~start_i;
            @(negedge clk);
            check_idle("reset");
        end
        start_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        run_block(64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0, 1'b0);

        r0 = racc_cnt;
        run_block(64'h5555_6666_7777_8888, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", {63'd0, busy_o}, '0);
        chk("ignored_start_reset_acc", DW'(racc_cnt), DW'(r0 + 1));

        run_block(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("error_sticky", {63'd0, error_o}, 64'd1);

        run_block(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0, 1'b0);

        core_done_en = 1'b1;
        q.push_back('{64'hFFFF_0000_FFFF_0000, 1'b0, NCH + 4});
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (fi >= 10) break;
        end
        rst_n = 1'b0;
        #1 check_idle("midrun_reset");
        q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        r0 = racc_cnt;
        run_block(64'h0F0F_1E1E_2D2D_3C3C, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrun_fresh_reset_acc", DW'(racc_cnt), DW'(r0 + 1));

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_results: got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
